// File: rtl/arc4_seq.sv
// ARC4 decrypt sequencer: runs init -> ksa -> prga over their en/rdy handshakes, owns the
// single S memory port and aborts any phase whose sub-block stays busy for too long.
module arc4_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic        err,
    output logic [1:0]  phase,

    output logic        init_en,
    input  logic        init_rdy,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_wrdata,
    input  logic        init_wren,

    output logic        ksa_en,
    input  logic        ksa_rdy,
    output logic [23:0] ksa_key,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  ksa_wrdata,
    input  logic        ksa_wren,

    output logic        prga_en,
    input  logic        prga_rdy,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  prga_wrdata,
    input  logic        prga_wren,

    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLimit = TimerW'(TIMEOUT_CYCLES);

    localparam logic [1:0] PhNone = 2'd0;
    localparam logic [1:0] PhInit = 2'd1;
    localparam logic [1:0] PhKsa  = 2'd2;
    localparam logic [1:0] PhPrga = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StInitGo,
        StInitWait,
        StKsaGo,
        StKsaWait,
        StPrgaGo,
        StPrgaWait,
        StDone
    } state_e;

    state_e             state_q;
    state_e             adv_state;
    logic               rdy_q;
    logic               err_q;
    logic [1:0]         phase_q;
    logic [23:0]        key_q;
    logic [TimerW-1:0]  timer_q;
    logic [TimerW-1:0]  timer_inc;
    logic               armed_q;
    logic               cur_rdy;

    assign rdy       = rdy_q;
    assign err       = err_q;
    assign phase     = phase_q;
    assign ksa_key   = key_q;
    assign timer_inc = timer_q + TimerW'(1);

    // Start pulses are gated by the sub-block's own rdy so a GO state simply waits for it.
    assign init_en = (state_q == StInitGo) && init_rdy;
    assign ksa_en  = (state_q == StKsaGo)  && ksa_rdy;
    assign prga_en = (state_q == StPrgaGo) && prga_rdy;

    // phase is already set in both GO and WAIT, so it selects the active sub-block's rdy.
    always_comb begin
        cur_rdy = 1'b0;
        unique case (phase_q)
            PhInit:  cur_rdy = init_rdy;
            PhKsa:   cur_rdy = ksa_rdy;
            PhPrga:  cur_rdy = prga_rdy;
            default: cur_rdy = 1'b0;
        endcase
    end

    // Successor state when the current GO or WAIT state completes its step.
    always_comb begin
        adv_state = StIdle;
        unique case (state_q)
            StInitGo:   adv_state = StInitWait;
            StInitWait: adv_state = StKsaGo;
            StKsaGo:    adv_state = StKsaWait;
            StKsaWait:  adv_state = StPrgaGo;
            StPrgaGo:   adv_state = StPrgaWait;
            StPrgaWait: adv_state = StDone;
            default:    adv_state = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            phase_q <= PhNone;
            key_q   <= 24'h0;
            timer_q <= '0;
            armed_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        key_q   <= key;
                        err_q   <= 1'b0;
                        rdy_q   <= 1'b0;
                        phase_q <= PhInit;
                        state_q <= StInitGo;
                    end
                end
                StInitGo, StKsaGo, StPrgaGo: begin
                    if (cur_rdy) begin
                        timer_q <= '0;
                        armed_q <= 1'b0;
                        state_q <= adv_state;
                    end
                end
                StInitWait, StKsaWait, StPrgaWait: begin
                    // armed filters out a stale rdy left over from before the en pulse.
                    if (armed_q && cur_rdy) begin
                        phase_q <= phase_q + 2'd1;
                        state_q <= adv_state;
                    end else if (timer_inc == TimerLimit) begin
                        err_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        phase_q <= PhNone;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_inc;
                        if (!cur_rdy) begin
                            armed_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    rdy_q   <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // S port follows the registered phase only, so non-owners can never write.
    always_comb begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
        unique case (phase_q)
            PhInit: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            PhKsa: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            PhPrga: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = 8'h00;
                s_wrdata = 8'h00;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_seq.sv
// Directed bench for arc4_seq: stub sub-blocks with configurable stale/busy rdy profiles,
// one instance with a long watchdog for the normal flows and one with a 50-cycle watchdog.
module tb_arc4_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        en [2];
    logic        rdy [2];
    logic        err [2];
    logic [23:0] key [2];
    logic [23:0] ksa_key [2];
    logic [1:0]  phase [2];
    logic        i_en [2];
    logic        k_en [2];
    logic        p_en [2];
    logic        i_rdy [2];
    logic        k_rdy [2];
    logic        p_rdy [2];
    logic [7:0]  s_addr [2];
    logic [7:0]  s_wrdata [2];
    logic        s_wren [2];

    logic [7:0]  addr_c [3];
    logic [7:0]  wd_c [3];
    logic        wren_c [3];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        arc4_seq #(.TIMEOUT_CYCLES(d == 0 ? 2000 : 50)) u_dut (
            .clk(clk), .rst(rst[d]), .en(en[d]), .rdy(rdy[d]), .key(key[d]),
            .err(err[d]), .phase(phase[d]),
            .init_en(i_en[d]), .init_rdy(i_rdy[d]), .init_addr(addr_c[0]),
            .init_wrdata(wd_c[0]), .init_wren(wren_c[0]),
            .ksa_en(k_en[d]), .ksa_rdy(k_rdy[d]), .ksa_key(ksa_key[d]), .ksa_addr(addr_c[1]),
            .ksa_wrdata(wd_c[1]), .ksa_wren(wren_c[1]),
            .prga_en(p_en[d]), .prga_rdy(p_rdy[d]), .prga_addr(addr_c[2]),
            .prga_wrdata(wd_c[2]), .prga_wren(wren_c[2]),
            .s_addr(s_addr[d]), .s_wrdata(s_wrdata[d]), .s_wren(s_wren[d])
        );
    end

    // Stub: after en, rdy stays high for cfg_stale cycles, then low for cfg_low cycles.
    int unsigned cnt [2][3];
    int unsigned cfg_stale [3];
    int unsigned cfg_low [3];

    function automatic logic blk_en(int d, int b);
        return (b == 0) ? i_en[d] : (b == 1) ? k_en[d] : p_en[d];
    endfunction

    function automatic logic stub_rdy(int unsigned c, int unsigned low);
        return !(c != 0 && c <= low);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 3; b++) begin
                if (rst[d]) cnt[d][b] <= 0;
                else if (blk_en(d, b)) cnt[d][b] <= cfg_stale[b] + cfg_low[b];
                else if (cnt[d][b] != 0) cnt[d][b] <= cnt[d][b] - 1;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            i_rdy[d] = stub_rdy(cnt[d][0], cfg_low[0]);
            k_rdy[d] = stub_rdy(cnt[d][1], cfg_low[1]);
            p_rdy[d] = stub_rdy(cnt[d][2], cfg_low[2]);
        end
    end

    // Start-pulse monitor for instance 0.
    int cyc, ie_n, ke_n, pe_n, ke_cyc, pe_cyc;
    int ord [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i_en[0]) begin ie_n <= ie_n + 1; ord.push_back(1); end
        if (k_en[0]) begin ke_n <= ke_n + 1; ke_cyc <= cyc; ord.push_back(2); end
        if (p_en[0]) begin pe_n <= pe_n + 1; pe_cyc <= cyc; ord.push_back(3); end
    end

    int n_cmp, n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [23:0] key;
        int          bi, bk, bp, stale_k;
        int          cycles;  // edges from en acceptance until rdy reads 1
        int          gap;     // edges from ksa_en to prga_en
    } vec_t;
    vec_t vecs [4];

    function automatic logic mux_ok();
        unique case (phase[0])
            2'd1:    return s_addr[0] == 8'h11 && s_wrdata[0] == 8'hA1 && s_wren[0] == 1'b1;
            2'd2:    return s_addr[0] == 8'h22 && s_wrdata[0] == 8'hA2 && s_wren[0] == 1'b1;
            2'd3:    return s_addr[0] == 8'h33 && s_wrdata[0] == 8'hA3 && s_wren[0] == 1'b1;
            default: return s_addr[0] == 8'h00 && s_wrdata[0] == 8'h00 && s_wren[0] == 1'b0;
        endcase
    endfunction

    task automatic run_row(input vec_t v);
        int n, bad_mux, np, b_ie, b_ke, b_pe, b_ord, code;
        logic [1:0] prev;
        logic [7:0] pseq;
        cfg_stale = '{1, v.stale_k, 1};
        cfg_low   = '{v.bi + 1, v.bk + 1, v.bp + 1};
        b_ie = ie_n; b_ke = ke_n; b_pe = pe_n; b_ord = ord.size();
        key[0] = v.key;
        en[0]  = 1'b1;
        step();
        en[0]  = 1'b0;
        key[0] = ~v.key;
        n = 0; bad_mux = 0;
        prev = phase[0]; pseq = {6'b0, phase[0]}; np = 1;
        while (rdy[0] !== 1'b1 && n < 3000) begin
            if (!mux_ok()) bad_mux++;
            step();
            n++;
            if (phase[0] !== prev) begin
                pseq = {pseq[5:0], phase[0]};
                np++;
                prev = phase[0];
            end
        end
        check("run_cycles", n, v.cycles);
        check("run_ksa_key", ksa_key[0], v.key);
        check("run_err", err[0], 0);
        check("run_init_pulses", ie_n - b_ie, 1);
        check("run_ksa_pulses", ke_n - b_ke, 1);
        check("run_prga_pulses", pe_n - b_pe, 1);
        code = (ord.size() - b_ord == 3) ? ord[b_ord] * 100 + ord[b_ord + 1] * 10 + ord[b_ord + 2]
                                         : -1;
        check("run_pulse_order", code, 123);
        check("run_phase_count", np, 4);
        check("run_phase_seq", pseq, 8'h6C);
        check("run_s_mux", bad_mux, 0);
        check("run_ksa_to_prga", pe_cyc - ke_cyc, v.gap);
    endtask

    initial begin
        int n, b_ie, b_tot;
        n_cmp = 0; n_bad = 0;
        addr_c = '{8'h11, 8'h22, 8'h33};
        wd_c   = '{8'hA1, 8'hA2, 8'hA3};
        wren_c = '{1'b1, 1'b1, 1'b1};
        cfg_stale = '{1, 1, 1};
        cfg_low   = '{4, 4, 4};
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; en[d] = 1'b0; key[d] = 24'h0;
        end
        // {key, busy init/ksa/prga, ksa stale, total edges, ksa_en->prga_en edges}
        vecs[0] = '{24'h000018, 256, 768, 40, 1, 1077, 772};
        vecs[1] = '{24'hABCDEF, 3, 5, 7, 1, 28, 9};
        vecs[2] = '{24'h123456, 4, 6, 8, 2, 32, 11};
        vecs[3] = '{24'hFFFFFF, 1, 1, 1, 1, 16, 5};

        repeat (2) step();
        check("rst_rdy", rdy[0], 1);
        check("rst_err", err[0], 0);
        check("rst_phase", phase[0], 0);
        check("rst_ksa_key", ksa_key[0], 0);
        check("rst_en_pulses", {i_en[0], k_en[0], p_en[0]}, 0);
        check("rst_s_addr", s_addr[0], 0);
        check("rst_s_wrdata", s_wrdata[0], 0);
        check("rst_s_wren", s_wren[0], 0);
        rst[0] = 1'b0;
        step();

        // en together with rst: reset must win.
        rst[0] = 1'b1; en[0] = 1'b1; key[0] = 24'h777777;
        step();
        rst[0] = 1'b0; en[0] = 1'b0;
        check("rst_en_key", ksa_key[0], 0);
        step();
        check("rst_en_rdy", rdy[0], 1);
        check("rst_en_phase", phase[0], 0);

        for (int i = 0; i < 4; i++) run_row(vecs[i]);

        // en while busy is ignored.
        cfg_stale = '{1, 1, 1};
        cfg_low   = '{11, 5, 5};
        b_ie = ie_n;
        key[0] = 24'h0000AA; en[0] = 1'b1;
        step();
        en[0] = 1'b0;
        repeat (3) step();
        key[0] = 24'h555555; en[0] = 1'b1;
        step();
        en[0] = 1'b0;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 200) begin step(); n++; end
        check("busy_rdy", rdy[0], 1);
        check("busy_ksa_key", ksa_key[0], 24'h0000AA);
        check("busy_init_pulses", ie_n - b_ie, 1);

        // Reset during KSA_WAIT.
        cfg_low = '{3, 21, 6};
        key[0] = 24'h0BEEF0; en[0] = 1'b1;
        step();
        en[0] = 1'b0;
        n = 0;
        while (phase[0] !== 2'd2 && n < 100) begin step(); n++; end
        repeat (3) step();
        check("mid_phase", phase[0], 2);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("mid_rst_rdy", rdy[0], 1);
        check("mid_rst_phase", phase[0], 0);
        check("mid_rst_key", ksa_key[0], 0);
        check("mid_rst_s_wren", s_wren[0], 0);
        b_tot = ie_n + ke_n + pe_n;
        repeat (40) step();
        check("mid_rst_no_pulses", ie_n + ke_n + pe_n - b_tot, 0);
        check("mid_rst_idle", rdy[0], 1);

        // Watchdog on the 50-cycle instance: prga never comes back.
        cfg_stale = '{1, 1, 1};
        cfg_low   = '{3, 3, 100000};
        rst[1] = 1'b0;
        step();
        key[1] = 24'h0C0FFE; en[1] = 1'b1;
        step();
        en[1] = 1'b0;
        n = 0;
        while (phase[1] !== 2'd3 && n < 200) begin step(); n++; end
        // Now in PRGA_GO; the next edge enters PRGA_WAIT, abort lands 50 edges after that.
        n = 0;
        while (err[1] !== 1'b1 && n < 200) begin step(); n++; end
        check("wd_cycles", n, 51);
        check("wd_rdy", rdy[1], 1);
        check("wd_phase", phase[1], 0);
        check("wd_s_wren", s_wren[1], 0);
        repeat (5) step();
        check("wd_err_sticky", err[1], 1);
        key[1] = 24'h000001; en[1] = 1'b1;
        step();
        en[1] = 1'b0;
        check("wd_err_cleared", err[1], 0);
        check("wd_restart_busy", rdy[1], 0);
        rst[1] = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arc4_seq.md
Name: arc4_seq

Overview:
- Top-level sequencer for the ARC4 decrypt datapath; runs init -> ksa -> prga in order using each sub-block's en/rdy handshake.
- Owns the single-port S memory and grants its port to exactly one sub-block per phase; the sub-blocks no longer drive S directly.
- Sits between the task top level (key from switches, start from reset release) and the three sub-blocks.
- Adds a per-phase watchdog so a hung sub-block reports an error instead of stalling forever.

Parameters:
- TIMEOUT_CYCLES, 100000, max cycles spent in any one WAIT state before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- en  in  1  start request; accepted only while rdy=1
- rdy  out  1  idle and able to accept en
- key  in  24  ARC4 key, sampled on accepted en
- err  out  1  sticky watchdog abort flag
- phase  out  2  0=none, 1=init, 2=ksa, 3=prga
- init_en  out  1  one-cycle start pulse to init
- init_rdy  in  1  init ready
- init_addr / init_wrdata  in  8 / 8  init S request
- init_wren  in  1  init S write enable
- ksa_en  out  1  one-cycle start pulse to ksa
- ksa_rdy  in  1  ksa ready
- ksa_key  out  24  latched key
- ksa_addr / ksa_wrdata  in  8 / 8  ksa S request
- ksa_wren  in  1  ksa S write enable
- prga_en  out  1  one-cycle start pulse to prga
- prga_rdy  in  1  prga ready
- prga_addr / prga_wrdata  in  8 / 8  prga S request
- prga_wren  in  1  prga S write enable
- s_addr / s_wrdata  out  8 / 8  to S memory
- s_wren  out  1  to S memory

Behaviour:
- Reset values:
  - state IDLE, rdy=1, err=0, phase=0.
  - all *_en=0, ksa_key=0, timer=0, armed=0.
  - s_addr, s_wrdata and s_wren = 0.
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, DONE.
- IDLE:
  - rdy=1.
  - en=1 at edge N: latch key into ksa_key, clear err, state=INIT_GO at N+1, rdy=0 from N+1.
  - en while rdy=0 is ignored.
- X_GO (X = init, ksa, prga):
  - phase set to X.
  - X_en=1 combinationally only while X_rdy=1; the state holds until X_rdy=1.
  - The cycle X_en is high, go to X_WAIT, clear timer and armed.
  - X_en is high for exactly one cycle per phase.
- X_WAIT:
  - Set armed when X_rdy=0 is seen.
  - Exit when armed=1 and X_rdy=1: INIT_WAIT->KSA_GO, KSA_WAIT->PRGA_GO, PRGA_WAIT->DONE.
  - A stale rdy=1 in the cycle right after the en pulse does not advance the state.
- DONE: phase=0 and rdy=0 for one cycle, then IDLE (rdy=1). Total handshake overhead is 3 cycles per phase plus 1 for DONE.
- Watchdog:
  - The timer increments every cycle in X_WAIT.
  - When timer reaches TIMEOUT_CYCLES: err=1, phase=0, state=IDLE (rdy=1) on the next edge.
  - err stays set until the next accepted en or rst.
- S port mux:
  - Combinational from the registered phase, so it adds zero latency and S read latency stays 1 cycle, seen directly by the owner.
  - phase=0 drives s_addr=0, s_wrdata=0, s_wren=0.
  - A non-owner's wren is ignored, even when several sub-blocks assert wren in the same cycle.
- rst mid-operation: abort in any state. Next cycle is IDLE with reset values, key cleared and no en pulses; sub-blocks are reset by their own reset.
- en and rst in the same cycle: rst wins.

Test Plan:
- Stub sub-blocks (rdy drops 1 cycle after en, busy 256/768/M cycles); key=24'h000018, pulse en -> one pulse each of init_en, ksa_en, prga_en in that order, ksa_key=24'h000018, phase sequence 1,2,3,0, rdy returns 1 exactly 1027+M+10 cycles after en, err=0.
- S mux: all three stubs drive wren=1 with addr 8'h11/8'h22/8'h33 -> s_addr=8'h11, 8'h22, 8'h33 in phases 1, 2, 3; s_wren=0 with phase=0.
- Stale ready: ksa stub keeps rdy=1 for 2 cycles after ksa_en -> the state stays in KSA_WAIT until rdy falls then rises; prga_en does not fire early.
- Watchdog with TIMEOUT_CYCLES=50: prga stub never returns rdy -> err=1 and rdy=1 exactly 50 cycles after entering PRGA_WAIT, phase=0; a new en clears err.
- Reset mid-KSA: assert rst for 1 cycle during KSA_WAIT -> next cycle rdy=1, phase=0, ksa_key=0, s_wren=0, no further *_en pulses.
- en while busy: pulse en during INIT_WAIT with a different key -> ignored, ksa_key keeps the original value.
